alu_sched: RTL and testbench
============================

# alu_sched

Request scheduler that shares one `ALU_rtl_design` instance among `NREQ` independent requesters. It arbitrates round-robin and issues one operation at a time to the ALU. It holds the ALU inputs stable for the command-dependent pipeline latency, captures the result and flags, and returns them tagged with the requester ID over a valid/ready response port. It sits between the client blocks and the ALU and is the only driver of the ALU input pins.

## Interface
- `N`, 8, operand width (matches ALU `N`)
- `M`, 4, command width (matches ALU `M`)
- `NREQ`, 4, number of requesters (2..8)
- `LAT`, 2, ALU latency for non-multiply commands (edges from ALU input capture to stable `RES`)
- `MUL_LAT`, 3, ALU latency for MODE=1, CMD=9 or CMD=10

- `CLK` in 1: clock
- `RST` in 1: reset, asynchronous, active-high
- `REQ_VALID` in NREQ: per-requester op valid
- `REQ_READY` out NREQ: one-hot grant/accept
- `REQ_OPA`, `REQ_OPB` in NREQ*N: packed operands, requester i at [i*N +: N]
- `REQ_CMD` in NREQ*M: packed commands
- `REQ_MODE`, `REQ_CIN` in NREQ: per-requester mode / carry-in
- `REQ_INP_VALID` in NREQ*2: packed operand-valid codes
- `ALU_OPA`, `ALU_OPB` out N; `ALU_CMD` out M; `ALU_MODE`, `ALU_CIN`, `ALU_CE` out 1; `ALU_INP_VALID` out 2: ALU drive
- `ALU_RES` in 2N; `ALU_COUT`, `ALU_OFLOW`, `ALU_G`, `ALU_E`, `ALU_L`, `ALU_ERR` in 1: ALU results
- `RSP_VALID` out 1; `RSP_READY` in 1: response handshake
- `RSP_ID` out clog2(NREQ): granted requester index
- `RSP_RES` out 2N: captured result
- `RSP_FLAGS` out 6: {ERR, L, E, G, OFLOW, COUT}

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any `REQ_VALID` set:
  - Grant the first valid requester strictly after pointer `last`, wrapping.
  - `REQ_READY[g]`=1 combinationally in that cycle.
  - Latch g's fields, set `last`=g, go to ISSUE.
- IDLE with no `REQ_VALID`: `REQ_READY` is all zero. `REQ_READY` is zero in every state except IDLE.
- ISSUE, one cycle:
  - Drive latched fields onto `ALU_*`, `ALU_CE`=1.
  - Load `cnt` = MUL_LAT-1 if latched MODE=1 and CMD∈{9,10}, else LAT-1. Go to WAIT.
- WAIT:
  - Keep `ALU_*` and `ALU_CE`=1 unchanged, since the ALU re-samples every cycle.
  - If `cnt`==0: capture `ALU_RES` and flags into the response registers, go to RESP. Else decrement `cnt`.
- RESP:
  - `RSP_VALID`=1, with `RSP_ID`, `RSP_RES` and `RSP_FLAGS` stable.
  - `ALU_CE`=0 and `ALU_INP_VALID`=0.
  - On `RSP_VALID`&&`RSP_READY`, go to IDLE. No grant is issued in that same cycle.
- No operand checking: illegal command/valid combinations pass through, and the ALU's ERR is reported in `RSP_FLAGS[5]`.
- Requester fields are sampled only in the grant cycle. Later changes have no effect.
- Reset, including mid-operation:
  - State IDLE, `last`=NREQ-1 so requester 0 wins first.
  - `cnt`=0; all `ALU_*` outputs 0; `RSP_*` 0; `REQ_READY` 0.
  - An in-flight op is dropped with no response.

## Timing
- Grant cycle c0 (IDLE), ISSUE c1. The ALU captures its inputs at the end of c1.
- Response timing:
  - `RSP_VALID` rises in c(2+LAT), i.e. c4 at default LAT.
  - Multiply commands: `RSP_VALID` rises in c(2+MUL_LAT), i.e. c5.
- Minimum spacing between grants: LAT+3 cycles (MUL_LAT+3 for multiply), plus any RESP stall cycles.
- `RSP_VALID` stays high until accepted. `RSP_READY` held low stalls indefinitely with all outputs stable.
- `REQ_VALID` dropping without a grant is legal, and that requester is simply skipped.

## Configuration
- `ALU_SCHED_PRIO0_EN` defined:
  - Requester 0 has strict priority: when `REQ_VALID[0]`=1 in IDLE it is granted regardless of `last`.
  - Requesters 1..NREQ-1 round-robin among themselves, and `last` is updated only by their grants.
- Undefined: pure round-robin over all requesters.

## Test plan
- Requester 1, MODE=1 CMD=0 (ADD), OPA=0x0F, OPB=0x01, INP_VALID=11 → `RSP_ID`=1, `RSP_RES`=0x0010, `RSP_FLAGS`=0, `RSP_VALID` in grant+4.
- Requester 0, MODE=1 CMD=9 (INC_MUL), OPA=3, OPB=4 → `RSP_RES`=0x0014, `RSP_VALID` in grant+5.
- Requester 2, INP_VALID=00 → `RSP_RES`=0, `RSP_FLAGS`=6'b100000.
- All four `REQ_VALID` held, `RSP_READY`=1 → grant order 0,1,2,3,0. Each grant is spaced 5 cycles.
- `RSP_READY`=0 for 10 cycles after `RSP_VALID` → outputs stable, `REQ_READY`=0 throughout. Acceptance occurs on the first cycle `RSP_READY`=1.
- Assert `RST` during WAIT → all outputs 0 immediately, no response. After release, requester 0 is granted first.
- With `ALU_SCHED_PRIO0_EN`: requesters 0 and 3 held valid, `last`=2 → requester 0 wins every IDLE.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: shares a single ALU among NREQ requesters.
// Requests are granted round-robin in IDLE. The granted fields are held on the
// ALU pins for the command-dependent latency, and the result is then returned
// tagged with the requester index over a valid/ready response port.
// Optional build macro: ALU_SCHED_PRIO0_EN gives requester 0 strict priority,
// and requesters 1..NREQ-1 round-robin among themselves.
module alu_sched #(
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int NREQ    = 4,
    parameter int LAT     = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ_VALID,
    output logic [NREQ-1:0]           REQ_READY,
    input  logic [NREQ*N-1:0]         REQ_OPA,
    input  logic [NREQ*N-1:0]         REQ_OPB,
    input  logic [NREQ*M-1:0]         REQ_CMD,
    input  logic [NREQ-1:0]           REQ_MODE,
    input  logic [NREQ-1:0]           REQ_CIN,
    input  logic [NREQ*2-1:0]         REQ_INP_VALID,
    output logic [N-1:0]              ALU_OPA,
    output logic [N-1:0]              ALU_OPB,
    output logic [M-1:0]              ALU_CMD,
    output logic                      ALU_MODE,
    output logic                      ALU_CIN,
    output logic                      ALU_CE,
    output logic [1:0]                ALU_INP_VALID,
    input  logic [2*N-1:0]            ALU_RES,
    input  logic                      ALU_COUT,
    input  logic                      ALU_OFLOW,
    input  logic                      ALU_G,
    input  logic                      ALU_E,
    input  logic                      ALU_L,
    input  logic                      ALU_ERR,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [$clog2(NREQ)-1:0]   RSP_ID,
    output logic [2*N-1:0]            RSP_RES,
    output logic [5:0]                RSP_FLAGS
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2((MUL_LAT > LAT) ? MUL_LAT : LAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [IDW-1:0]     r_last;
    logic [CW-1:0]      r_cnt;
    logic [N-1:0]       r_opa;
    logic [N-1:0]       r_opb;
    logic [M-1:0]       r_cmd;
    logic               r_mode;
    logic               r_cin;
    logic [1:0]         r_iv;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*N-1:0]     r_rsp_res;
    logic [5:0]         r_rsp_flags;

    logic [NREQ-1:0]    w_cand;
    logic [IDW-1:0]     w_rot_idx [NREQ];
    logic               w_rr_found;
    logic [IDW-1:0]     w_rr_idx;
    logic               w_grant_any;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_upd_last;
    logic               w_is_mul;

    logic [NREQ-1:0]    w_req_ready;
    logic               w_latch;
    logic               w_load_cnt;
    logic               w_dec_cnt;
    logic               w_capture;
    logic               w_alu_ce;
    logic               w_rsp_valid;

    // Index visited at each offset 1..NREQ after the last grant, wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] w_sum;
            assign w_sum = {1'b0, r_last} + (IDW+1)'(gi + 1);
            assign w_rot_idx[gi] = (w_sum >= (IDW+1)'(NREQ)) ?
                                   IDW'(w_sum - (IDW+1)'(NREQ)) : w_sum[IDW-1:0];
        end
    endgenerate

`ifdef ALU_SCHED_PRIO0_EN
    // Requester 0 bypasses the rotation and never moves the pointer.
    assign w_cand      = REQ_VALID & {{(NREQ-1){1'b1}}, 1'b0};
    assign w_grant_any = REQ_VALID[0] | w_rr_found;
    assign w_grant_idx = REQ_VALID[0] ? '0 : w_rr_idx;
    assign w_upd_last  = ~REQ_VALID[0];
`else
    assign w_cand      = REQ_VALID;
    assign w_grant_any = w_rr_found;
    assign w_grant_idx = w_rr_idx;
    assign w_upd_last  = 1'b1;
`endif

    // Pick the nearest valid candidate after the pointer. The scan runs from
    // the far end, so the closest hit is the one that is kept.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_cand[w_rot_idx[k]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_rot_idx[k];
            end
        end
    end

    assign w_is_mul = r_mode && ((r_cmd == M'(9)) || (r_cmd == M'(10)));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode. The grant is suppressed while reset is
    // asserted, so REQ_READY reads zero during reset.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = '0;
        w_latch      = 1'b0;
        w_load_cnt   = 1'b0;
        w_dec_cnt    = 1'b0;
        w_capture    = 1'b0;
        w_alu_ce     = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any && !RST) begin
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_latch      = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_alu_ce     = 1'b1;
                w_load_cnt   = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_alu_ce = 1'b1;
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end else begin
                    w_dec_cnt = 1'b1;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (RSP_READY) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch the granted requester's fields and advance the pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_cmd    <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_iv     <= 2'b00;
            r_rsp_id <= '0;
            r_last   <= IDW'(NREQ - 1);
        end else if (w_latch) begin
            r_opa    <= REQ_OPA[w_grant_idx*N +: N];
            r_opb    <= REQ_OPB[w_grant_idx*N +: N];
            r_cmd    <= REQ_CMD[w_grant_idx*M +: M];
            r_mode   <= REQ_MODE[w_grant_idx];
            r_cin    <= REQ_CIN[w_grant_idx];
            r_iv     <= REQ_INP_VALID[w_grant_idx*2 +: 2];
            r_rsp_id <= w_grant_idx;
            if (w_upd_last) begin
                r_last <= w_grant_idx;
            end
        end
    end

    // Latency countdown. Multiply commands need the longer pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_load_cnt) begin
            r_cnt <= w_is_mul ? CW'(MUL_LAT - 1) : CW'(LAT - 1);
        end else if (w_dec_cnt) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Capture the ALU result and flags once the pipeline has settled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
        end else if (w_capture) begin
            r_rsp_res   <= ALU_RES;
            r_rsp_flags <= {ALU_ERR, ALU_L, ALU_E, ALU_G, ALU_OFLOW, ALU_COUT};
        end
    end

    assign REQ_READY     = w_req_ready;
    assign ALU_OPA       = r_opa;
    assign ALU_OPB       = r_opb;
    assign ALU_CMD       = r_cmd;
    assign ALU_MODE      = r_mode;
    assign ALU_CIN       = r_cin;
    assign ALU_CE        = w_alu_ce;
    assign ALU_INP_VALID = w_alu_ce ? r_iv : 2'b00;
    assign RSP_VALID     = w_rsp_valid;
    assign RSP_ID        = r_rsp_id;
    assign RSP_RES       = r_rsp_res;
    assign RSP_FLAGS     = r_rsp_flags;

endmodule

// File: tb/tb_alu_sched.sv
// Testbench for alu_sched: drives vectors from a table through single-requester
// operations, then runs hand-written sequences for round-robin order, response
// stall, reset mid-operation and the requester-0 priority option
// (ALU_SCHED_PRIO0_EN). A small ALU model with pipeline latency feeds ALU_*.
module tb_alu_sched;

    localparam int N       = 8;
    localparam int M       = 4;
    localparam int NREQ    = 4;
    localparam int LAT     = 2;
    localparam int MUL_LAT = 3;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    REQ_VALID;
    logic [NREQ-1:0]    REQ_READY;
    logic [NREQ*N-1:0]  REQ_OPA;
    logic [NREQ*N-1:0]  REQ_OPB;
    logic [NREQ*M-1:0]  REQ_CMD;
    logic [NREQ-1:0]    REQ_MODE;
    logic [NREQ-1:0]    REQ_CIN;
    logic [NREQ*2-1:0]  REQ_INP_VALID;
    logic [N-1:0]       ALU_OPA;
    logic [N-1:0]       ALU_OPB;
    logic [M-1:0]       ALU_CMD;
    logic               ALU_MODE;
    logic               ALU_CIN;
    logic               ALU_CE;
    logic [1:0]         ALU_INP_VALID;
    logic [2*N-1:0]     ALU_RES;
    logic               ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
    logic               RSP_VALID;
    logic               RSP_READY;
    logic [1:0]         RSP_ID;
    logic [2*N-1:0]     RSP_RES;
    logic [5:0]         RSP_FLAGS;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_sched #(.N(N), .M(M), .NREQ(NREQ), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
        .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD),
        .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_CE(ALU_CE),
        .ALU_INP_VALID(ALU_INP_VALID),
        .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
        .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
    );

    // ALU model: returns {ERR,L,E,G,OFLOW,COUT, RES[15:0]}
    function automatic logic [21:0] alu_f(input logic mode, input logic [3:0] cmd,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [1:0] iv);
        logic [15:0] r;
        logic [5:0]  f;
        r = '0;
        f = '0;
        if (iv != 2'b11) begin
            f[5] = 1'b1;
        end else if (mode) begin
            case (cmd)
                4'd0:  begin r = 16'(a) + 16'(b); f[0] = r[8]; end
                4'd1:  begin r = {8'h00, 8'(a - b)}; f[1] = (a < b); end
                4'd2:  begin r = 16'(a) + 16'(b) + 16'(cin); f[0] = r[8]; end
                4'd8:  begin f[2] = (a > b); f[3] = (a == b); f[4] = (a < b); end
                4'd9:  r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                4'd10: r = 16'({a[6:0], 1'b0}) * 16'(b);
                default: f[5] = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:  r = {8'h00, a & b};
                4'd1:  r = {8'h00, a | b};
                4'd2:  r = {8'h00, a ^ b};
                default: f[5] = 1'b1;
            endcase
        end
        return {f, r};
    endfunction

    logic [21:0] p1 = '0, p2 = '0, p3 = '0;
    logic [21:0] alu_sel;
    logic        alu_is_mul;

    always @(posedge CLK) begin
        p1 <= ALU_CE ? alu_f(ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_INP_VALID) : '0;
        p2 <= p1;
        p3 <= p2;
    end

    assign alu_is_mul = ALU_MODE && ((ALU_CMD == 4'd9) || (ALU_CMD == 4'd10));
    assign alu_sel    = alu_is_mul ? p3 : p2;
    assign ALU_RES    = alu_sel[15:0];
    assign {ALU_ERR, ALU_L, ALU_E, ALU_G, ALU_OFLOW, ALU_COUT} = alu_sel[21:16];

    typedef struct {
        int          id;
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [1:0]  iv;
        logic [15:0] res;
        logic [5:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[10];
    logic [NREQ-1:0] g_oh [8];
    int              g_cyc [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_fields(input int id, input logic mode, input logic [3:0] cmd,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic [1:0] iv);
        REQ_MODE[id]              = mode;
        REQ_CMD[id*M +: M]        = cmd;
        REQ_OPA[id*N +: N]        = a;
        REQ_OPB[id*N +: N]        = b;
        REQ_CIN[id]               = cin;
        REQ_INP_VALID[id*2 +: 2]  = iv;
    endtask

    // One full operation from a single requester with RSP_READY held high.
    task automatic do_op(input vec_t v, input int k);
        int n;
        REQ_VALID = '0;
        set_fields(v.id, v.mode, v.cmd, v.a, v.b, v.cin, v.iv);
        REQ_VALID[v.id] = 1'b1;
        RSP_READY = 1'b1;
        #1;
        chk($sformatf("v%0d grant", k), 32'(REQ_READY), 32'(1 << v.id));
        tick();
        // scramble requester fields: only the grant-cycle values may matter
        REQ_VALID = '0;
        REQ_OPA = '1; REQ_OPB = '1; REQ_CMD = '1; REQ_INP_VALID = '0;
        chk($sformatf("v%0d issue opa", k), 32'({ALU_CE, ALU_INP_VALID, ALU_OPA}),
            32'({1'b1, v.iv, v.a}));
        n = 1;
        while (!RSP_VALID && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d latency", k), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d id", k), 32'(RSP_ID), 32'(v.id));
        chk($sformatf("v%0d res", k), 32'(RSP_RES), 32'(v.res));
        chk($sformatf("v%0d flags", k), 32'(RSP_FLAGS), 32'(v.flags));
        $display("op %0d: id=%0d mode=%0d cmd=%0d a=%02h b=%02h -> id=%0d res=%04h flags=%06b lat=%0d",
                 k, v.id, v.mode, v.cmd, v.a, v.b, RSP_ID, RSP_RES, RSP_FLAGS, n);
        tick();
        chk($sformatf("v%0d rsp drop", k), 32'(RSP_VALID), 32'd0);
    endtask

    // Record the next n grants (one-hot and cycle) with a cycle budget.
    task automatic collect(input int n);
        int got = 0;
        int t = 0;
        while (got < n && t < 100) begin
            if (REQ_READY != '0) begin
                g_oh[got]  = REQ_READY;
                g_cyc[got] = cyc;
                $display("grant %0d: ready=%04b cycle=%0d", got, REQ_READY, cyc);
                got++;
            end
            tick();
            t++;
        end
        chk("collect count", 32'(got), 32'(n));
    endtask

    task automatic drain();
        int t = 0;
        RSP_READY = 1'b1;
        while (!RSP_VALID && t < 30) begin
            tick();
            t++;
        end
        chk("drain rsp", 32'(RSP_VALID), 32'd1);
        tick();
    endtask

    initial begin
        vecs[0] = '{1, 1'b1, 4'd0,  8'h0F, 8'h01, 1'b0, 2'b11, 16'h0010, 6'b000000, 4};
        vecs[1] = '{0, 1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 2'b11, 16'h0014, 6'b000000, 5};
        vecs[2] = '{2, 1'b1, 4'd0,  8'h12, 8'h34, 1'b0, 2'b00, 16'h0000, 6'b100000, 4};
        vecs[3] = '{3, 1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 2'b11, 16'h0100, 6'b000001, 4};
        vecs[4] = '{1, 1'b1, 4'd2,  8'h10, 8'h20, 1'b1, 2'b11, 16'h0031, 6'b000000, 4};
        vecs[5] = '{0, 1'b1, 4'd10, 8'h05, 8'h06, 1'b0, 2'b11, 16'h003C, 6'b000000, 5};
        vecs[6] = '{2, 1'b1, 4'd8,  8'h07, 8'h03, 1'b0, 2'b11, 16'h0000, 6'b000100, 4};
        vecs[7] = '{3, 1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 2'b11, 16'h0030, 6'b000000, 4};
        vecs[8] = '{1, 1'b0, 4'd9,  8'h03, 8'h04, 1'b0, 2'b11, 16'h0000, 6'b100000, 4};
        vecs[9] = '{0, 1'b1, 4'd1,  8'h05, 8'h07, 1'b0, 2'b11, 16'h00FE, 6'b000010, 4};

        RST = 1'b1;
        REQ_VALID = '1;
        REQ_OPA = '0; REQ_OPB = '0; REQ_CMD = '0;
        REQ_MODE = '0; REQ_CIN = '0; REQ_INP_VALID = '0;
        RSP_READY = 1'b0;
        tick();
        // reset state
        chk("rst req_ready", 32'(REQ_READY), 32'd0);
        chk("rst rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst rsp", 32'({RSP_ID, RSP_FLAGS, RSP_RES}), 32'd0);
        chk("rst alu", 32'({ALU_CE, ALU_INP_VALID, ALU_MODE, ALU_CIN, ALU_CMD, ALU_OPB, ALU_OPA}), 32'd0);
        REQ_VALID = '0;
        RST = 1'b0;
        tick();

        // table-driven single-requester operations
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], i);
        end

        // round-robin with all four requesters held valid, from reset
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) set_fields(i, 1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
        REQ_VALID = '1;
        RSP_READY = 1'b1;
        #1;
        collect(5);
        chk("rr g0", 32'(g_oh[0]), 32'h1);
        chk("rr g1", 32'(g_oh[1]), 32'h2);
        chk("rr g2", 32'(g_oh[2]), 32'h4);
        chk("rr g3", 32'(g_oh[3]), 32'h8);
        chk("rr g4", 32'(g_oh[4]), 32'h1);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("rr spacing %0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
        end
        REQ_VALID = '0;
        drain();

        // response stall: RSP_READY low for 10 cycles, other requesters waiting
        set_fields(1, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 2'b11);
        REQ_VALID = 4'b0010;
        RSP_READY = 1'b0;
        #1;
        chk("stall grant", 32'(REQ_READY), 32'h2);
        tick();
        REQ_VALID = '1;
        for (int t = 0; t < 20 && !RSP_VALID; t++) tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall %0d valid", i), 32'(RSP_VALID), 32'd1);
            chk($sformatf("stall %0d data", i), 32'({RSP_ID, RSP_FLAGS, RSP_RES}),
                32'({2'd1, 6'b000000, 16'h0010}));
            chk($sformatf("stall %0d ready", i), 32'(REQ_READY), 32'd0);
            tick();
        end
        RSP_READY = 1'b1;
        #1;
        chk("accept cycle valid", 32'(RSP_VALID), 32'd1);
        chk("accept cycle no grant", 32'(REQ_READY), 32'd0);
        tick();
        chk("after accept valid", 32'(RSP_VALID), 32'd0);
        chk("after accept grant", 32'(REQ_READY), 32'h4);
        $display("stall: response accepted, next grant ready=%04b", REQ_READY);

        // reset while requester 2 is in WAIT
        set_fields(0, 1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
        tick();
        tick();
        RST = 1'b1;
        #1;
        chk("midrst alu", 32'({ALU_CE, ALU_INP_VALID, ALU_MODE, ALU_CIN, ALU_CMD, ALU_OPB, ALU_OPA}), 32'd0);
        chk("midrst rsp", 32'({RSP_VALID, RSP_ID, RSP_FLAGS, RSP_RES}), 32'd0);
        chk("midrst ready", 32'(REQ_READY), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("post rst grant", 32'(REQ_READY), 32'h1);
        tick();
        REQ_VALID = '0;
        for (int t = 0; t < 20 && !RSP_VALID; t++) tick();
        chk("post rst rsp id", 32'({RSP_VALID, RSP_ID}), 32'({1'b1, 2'd0}));
        chk("post rst rsp res", 32'(RSP_RES), 32'h0002);
        $display("reset: first response id=%0d res=%04h", RSP_ID, RSP_RES);
        tick();

        // requesters 0 and 3 held valid with last=2
        do_op(vecs[2], 2);
        set_fields(0, 1'b1, 4'd0, 8'h02, 8'h02, 1'b0, 2'b11);
        set_fields(3, 1'b1, 4'd0, 8'h03, 8'h03, 1'b0, 2'b11);
        REQ_VALID = 4'b1001;
        RSP_READY = 1'b1;
        #1;
        collect(3);
`ifdef ALU_SCHED_PRIO0_EN
        chk("prio g0", 32'(g_oh[0]), 32'h1);
        chk("prio g1", 32'(g_oh[1]), 32'h1);
        chk("prio g2", 32'(g_oh[2]), 32'h1);
`else
        chk("rr03 g0", 32'(g_oh[0]), 32'h8);
        chk("rr03 g1", 32'(g_oh[1]), 32'h1);
        chk("rr03 g2", 32'(g_oh[2]), 32'h8);
`endif
        REQ_VALID = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
